// File: rtl/led_scan_controller_pkg.sv
// Shared constants, scan FSM encoding and digit-blanking helper for the LED scan controller.
package led_scan_controller_pkg;

   localparam logic LED_COMMON_ANODE   = 1'b0;
   localparam logic LED_COMMON_CATHODE = 1'b1;
   localparam int   NIBBLE_W           = 4;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_e;

   typedef struct packed {
      scan_state_e state;
      logic        in_blank;
      logic [2:0]  idx;
   } scan_dbg_t;

   // value is zero-extended to 8 digits, so "all digits at idx and above" needs no width knowledge.
   function automatic logic digit_blank(input logic [31:0] value,
                                        input logic [2:0]  idx,
                                        input logic        blank_zero);
      logic upper_zero;
      logic invalid;
      upper_zero = 1'b1;
      invalid    = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (3'(i) == idx)
            invalid = (value[i*NIBBLE_W +: NIBBLE_W] > 4'd9);
         if ((3'(i) >= idx) && (value[i*NIBBLE_W +: NIBBLE_W] != 4'd0))
            upper_zero = 1'b0;
      end
      return invalid || (blank_zero && (idx != 3'd0) && upper_zero);
   endfunction

endpackage

// File: rtl/led_scan_controller_tick.sv
// Prescale counter for one digit slot: flags the slot end and the anti-ghosting dead time.
module led_scan_tick #(
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   output logic slot_end,
   output logic blank_end,
   output logic in_blank
);

   localparam int CW = $clog2(PRESCALE);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (slot_end)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign slot_end  = (cnt == CW'(PRESCALE - 1));
   assign blank_end = (cnt == CW'(BLANK_CYCLES - 1));
   assign in_blank  = (cnt <  CW'(BLANK_CYCLES));

endmodule

// File: rtl/led_scan_controller.sv
// Multiplexes one BCD-to-7-segment decoder across NUM_DIGITS digits with a double-buffered value.
module led_scan_controller
   import led_scan_controller_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           load,
   input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
   input  logic                           blank_zero,
   input  logic                           led_type,
   output logic [NIBBLE_W-1:0]            bcd_out,
   output logic                           blank,
   output logic [NUM_DIGITS-1:0]          digit_en,
   output logic                           busy,
   output logic                           frame_done,
   output scan_dbg_t                      dbg
);

   localparam int         VW       = NIBBLE_W * NUM_DIGITS;
   localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

   logic                  slot_end, blank_end, in_blank;
   scan_state_e           state, state_nxt;
   logic [2:0]            idx, idx_nxt;
   logic [VW-1:0]         active, active_nxt, pending, pending_nxt;
   logic                  busy_nxt, frame_end;
   logic [NIBBLE_W-1:0]   bcd_nxt;
   logic                  blank_nxt;
   logic [NUM_DIGITS-1:0] en_onehot, en_nxt;

   led_scan_tick #(
      .PRESCALE     (PRESCALE),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_tick (
      .clk       (clk),
      .reset     (reset),
      .slot_end  (slot_end),
      .blank_end (blank_end),
      .in_blank  (in_blank)
   );

   // Outputs are registered from next-state values so they line up with the state they describe.
   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      active_nxt  = active;
      pending_nxt = pending;
      busy_nxt    = busy;
      bcd_nxt     = '0;
      frame_end   = slot_end && (idx == LAST_IDX);

      case (state)
         BLANK:   if (blank_end) state_nxt = SHOW;
         SHOW:    if (slot_end)  state_nxt = BLANK;
         default: state_nxt = BLANK;
      endcase

      if (slot_end)
         idx_nxt = frame_end ? 3'd0 : idx + 3'd1;

      if (load) begin
         pending_nxt = value_in;
         busy_nxt    = 1'b1;
      end

      // A load landing on the frame boundary goes straight to the active buffer.
      if (frame_end) begin
         if (load)
            active_nxt = value_in;
         else if (busy)
            active_nxt = pending;
         busy_nxt = 1'b0;
      end

      for (int i = 0; i < NUM_DIGITS; i++)
         if (idx_nxt == 3'(i))
            bcd_nxt = active_nxt[i*NIBBLE_W +: NIBBLE_W];

      blank_nxt = digit_blank(32'(active_nxt), idx_nxt, blank_zero);

      en_onehot = '0;
      if ((state_nxt == SHOW) && !blank_nxt)
         en_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_nxt;

      en_nxt = (led_type == LED_COMMON_CATHODE) ? en_onehot : ~en_onehot;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= BLANK;
         idx        <= 3'd0;
         active     <= '0;
         pending    <= '0;
         busy       <= 1'b0;
         bcd_out    <= '0;
         blank      <= 1'b1;
         digit_en   <= (led_type == LED_COMMON_CATHODE) ? '0 : '1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         active     <= active_nxt;
         pending    <= pending_nxt;
         busy       <= busy_nxt;
         bcd_out    <= bcd_nxt;
         blank      <= blank_nxt;
         digit_en   <= en_nxt;
         frame_done <= frame_end;
      end
   end

   always_comb begin
      dbg.state    = state;
      dbg.in_blank = in_blank;
      dbg.idx      = idx;
   end

endmodule
